// File: rtl/coi2_comb_decimator.sv
// Second-order comb and decimator for the sinc2 ADC path, with a valid/ready output register.
// Optional COI2_COMB_ROUND_EN: round-half-up with saturation instead of a truncating shift.
module coi2_comb_decimator #(
  parameter int DATA_W = 32,
  parameter int OSR_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [OSR_W-1:0]        osr,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-SHIFT-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    overrun
);

  localparam int OUT_W = DATA_W - SHIFT;

  logic              en_q;
  logic [OSR_W-1:0]  osr_q;
  logic [OSR_W-1:0]  cnt;
  logic [1:0]        warm;
  logic [DATA_W-1:0] z1;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] c1;
  logic [DATA_W-1:0] c2;
  logic [OUT_W-1:0]  res;
  logic              rise;
  logic              tick;
  logic              res_vld;

  assign rise    = en && !en_q;
  assign tick    = en_q && (cnt == osr_q - 1'b1);
  assign res_vld = tick && (warm == 2'd2);
  assign c1      = din - z1;
  assign c2      = c1 - d1;

`ifdef COI2_COMB_ROUND_EN
  if (SHIFT > 0) begin : g_rnd
    // adding bit SHIFT-1 to the shifted value is the half-LSB round
    logic [OUT_W:0] rnd;
    assign rnd = {1'b0, c2[DATA_W-1:SHIFT]}
               + {{OUT_W{1'b0}}, c2[SHIFT-1]};
    assign res = rnd[OUT_W] ? '1 : rnd[OUT_W-1:0];
  end else begin : g_trn
    assign res = c2;
  end
`else
  assign res = c2[DATA_W-1:SHIFT];
`endif

  if (SHIFT > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^c2[SHIFT-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      en_q       <= 1'b0;
      cnt        <= '0;
      warm       <= '0;
      z1         <= '0;
      d1         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      if (!rst_n) osr_q <= '0;
    end else begin
      en_q <= 1'b1;
      if (rise) begin
        osr_q <= (osr < OSR_W'(2)) ? OSR_W'(2) : osr;
        cnt   <= '0;
      end else if (tick) begin
        cnt <= '0;
        z1  <= din;
        d1  <= c1;
        if (warm != 2'd2) warm <= warm + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (res_vld) begin
        dout       <= res;
        dout_valid <= 1'b1;
        if (dout_valid && !dout_ready) overrun <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_coi2_comb_decimator.sv
// Bench for coi2_comb_decimator: table vectors, random bitstreams against
// a sample-level sinc2 model, and hand sequences for the handshake corners.
module tb_coi2_comb_decimator;

  typedef struct {
    int          osr;
    int          mode;
    logic [31:0] off;
    int          nres;
    logic [31:0] expv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] osr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;

  logic        en2;
  logic [15:0] osr2;
  logic [31:0] din2;
  logic [29:0] dout2;
  logic        valid2;
  logic        ready2;
  logic        ovr2;

  logic        rst_adc;
  logic        x;
  logic [31:0] ioff;
  logic [31:0] i1;
  logic [31:0] i2;

  int          checks = 0;
  int          errors = 0;
  int          n;
  int          rr;
  int          mode;
  logic        osr_jit = 1'b0;
  logic [31:0] smp[$];
  logic [31:0] expq[$];
  vec_t        tbl[7];

  always #5 clk = ~clk;

  // behavioural integrator cascade feeding the DUT
  always @(posedge clk) begin
    if (rst_adc) begin
      i1 <= '0;
      i2 <= ioff;
    end else begin
      i1 <= i1 + {31'd0, x};
      i2 <= i2 + i1;
    end
  end
  assign din = i2;

  coi2_comb_decimator #(.DATA_W(32), .OSR_W(16), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .osr(osr), .din(din),
    .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .overrun(overrun)
  );

  coi2_comb_decimator #(.DATA_W(32), .OSR_W(16), .SHIFT(2)) u_shf (
    .clk(clk), .rst_n(rst_n), .en(en2), .osr(osr2), .din(din2),
    .dout(dout2), .dout_valid(valid2),
    .dout_ready(ready2), .overrun(ovr2)
  );

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // one cycle; ticks fall every rr edges after the en edge, and the
  // model takes the sinc2 second difference of the sampled din values
  task automatic step();
    step_clk();
    n++;
    if (en && ((n + 1) % rr == 0)) begin
      smp.push_back(din);
      if (smp.size() >= 3)
        expq.push_back(smp[$] - 32'd2 * smp[$-1] + smp[$-2]);
    end
    if (mode == 1) x = ~x;
    else if (mode == 2) x = 1'($urandom);
    if (osr_jit) osr = 16'($urandom);
  endtask

  task automatic start(int o, logic [31:0] off, int m);
    en = 1'b0;
    rst_adc = 1'b1;
    ioff = off;
    repeat (2) step_clk();
    smp.delete();
    expq.delete();
    mode = m;
    x = (m == 2) ? 1'($urandom) : 1'b1;
    osr = 16'(o);
    rr = (o < 2) ? 2 : o;
    n = -1;
    en = 1'b1;
    rst_adc = 1'b0;
  endtask

  task automatic run_vec(vec_t v, bit strict);
    int          got;
    int          first;
    logic        pv;
    logic [31:0] e;
    got = 0;
    first = -1;
    pv = 1'b0;
    start(v.osr, v.off, v.mode);
    dout_ready = 1'b1;
    while (got < v.nres && n < rr * (v.nres + 3) + 8) begin
      step();
      if (dout_valid) begin
        if (first < 0) first = n;
        check("valid_one_cycle", 64'(pv), 64'd0);
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        check("dout_model", 64'(dout), 64'(e));
        if (strict) check("dout_table", 64'(dout), 64'(v.expv));
        check("overrun_idle", 64'(overrun), 64'd0);
        got++;
      end
      pv = dout_valid;
    end
    check("result_count", 64'(got), 64'(v.nres));
    check("first_valid_cycle", 64'(first), 64'(3 * rr));
  endtask

  task automatic round_case(string name, logic [31:0] c, logic [63:0] e);
    en2 = 1'b0;
    din2 = '0;
    repeat (2) step_clk();
    en2 = 1'b1;
    repeat (5) step_clk();
    din2 = c;
    repeat (2) step_clk();
    check({name, "_valid"}, 64'(valid2), 64'd1);
    check(name, 64'(dout2), e);
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{4,   0, 32'd0,          4, 32'd16};
    tbl[1] = '{4,   1, 32'd0,          4, 32'd8};
    tbl[2] = '{256, 0, 32'hFFFE_7960,  3, 32'd65536};
    tbl[3] = '{8,   0, 32'd0,          3, 32'd64};
    tbl[4] = '{1,   0, 32'd0,          4, 32'd4};
    tbl[5] = '{2,   1, 32'd0,          4, 32'd2};
    tbl[6] = '{5,   0, 32'd0,          3, 32'd25};

    rst_n = 1'b0;
    en = 1'b0;
    osr = '0;
    dout_ready = 1'b0;
    rst_adc = 1'b1;
    x = 1'b0;
    ioff = '0;
    en2 = 1'b0;
    osr2 = 16'd2;
    din2 = '0;
    ready2 = 1'b0;
    rr = 2;
    mode = 0;
    n = -1;
    repeat (3) step_clk();
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], 1'b1);

    osr_jit = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rv = '{$urandom_range(2, 12), 2, $urandom, 5, 32'd0};
      run_vec(rv, 1'b0);
    end
    osr_jit = 1'b0;

    // two results with no consumer: second overwrites first
    start(4, 32'd0, 2);
    dout_ready = 1'b0;
    while (n < 12) step();
    check("bp_valid1", 64'(dout_valid), 64'd1);
    check("bp_dout1", 64'(dout), 64'(expq[$]));
    check("bp_ovr1", 64'(overrun), 64'd0);
    while (n < 16) step();
    check("bp_valid2", 64'(dout_valid), 64'd1);
    check("bp_dout2", 64'(dout), 64'(expq[$]));
    check("bp_ovr2", 64'(overrun), 64'd1);
    step();
    en = 1'b0;
    step();
    check("abort_valid", 64'(dout_valid), 64'd0);
    check("abort_ovr", 64'(overrun), 64'd0);
    run_vec(tbl[3], 1'b1);

    // consumer accepts in the same cycle a new result lands
    start(4, 32'd0, 2);
    dout_ready = 1'b0;
    while (n < 15) step();
    dout_ready = 1'b1;
    step();
    check("same_valid", 64'(dout_valid), 64'd1);
    check("same_dout", 64'(dout), 64'(expq[$]));
    check("same_ovr", 64'(overrun), 64'd0);
    step();
    check("same_drain", 64'(dout_valid), 64'd0);

    // reset wins over en with a sample pending
    start(4, 32'd0, 0);
    dout_ready = 1'b0;
    while (n < 12) step();
    check("pre_rst_valid", 64'(dout_valid), 64'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 64'(dout_valid), 64'd0);
    check("mid_rst_dout", 64'(dout), 64'd0);
    rst_n = 1'b1;
    en = 1'b0;

`ifdef COI2_COMB_ROUND_EN
    round_case("round_14", 32'd14, 64'd4);
    round_case("round_15", 32'd15, 64'd4);
`else
    round_case("round_14", 32'd14, 64'd3);
    round_case("round_15", 32'd15, 64'd3);
`endif
    round_case("round_13", 32'd13, 64'd3);
    round_case("round_sat", 32'hFFFF_FFFF, 64'h3FFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
